// File: rtl/branch_predict_gs.sv
// Dual-slot gshare branch predictor with a tagged BTB and a return-address stack.
// Lookup is combinational; tables, history and RAS update on the clock edge.
module branch_predict_gs #(
    parameter int unsigned BhtSize  = 64,
    parameter int unsigned BtbSize  = 16,
    parameter int unsigned BtbTagW  = 8,
    parameter int unsigned GhrLen   = 6,
    parameter int unsigned RasDepth = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        fetch_valid_i,
    input  logic [31:0]       fetch_pc0_i,
    input  logic [31:0]       fetch_pc1_i,
    input  logic [1:0]        fetch_is_br_i,
    input  logic [1:0]        fetch_is_jal_i,
    input  logic [1:0]        fetch_is_call_i,
    input  logic [1:0]        fetch_is_ret_i,
    input  logic [1:0]        fetch_is_comp_i,
    input  logic [1:0]        ds_rdy_i,
    output logic [1:0]        pdt_valid_o,
    output logic [1:0]        pdt_taken_o,
    output logic [GhrLen-1:0] pdt_ghr0_o,
    output logic [GhrLen-1:0] pdt_ghr1_o,
    output logic              predict_pc_set_o,
    output logic [31:0]       predict_pc_target_o,
    input  logic              ex_valid_i,
    input  logic [31:0]       ex_pc_i,
    input  logic              ex_is_br_i,
    input  logic              ex_is_jal_i,
    input  logic              ex_taken_i,
    input  logic              ex_mispredict_i,
    input  logic [31:0]       ex_target_i,
    input  logic [GhrLen-1:0] ex_ghr_i
);

    localparam int unsigned BhtIdxW = $clog2(BhtSize);
    localparam int unsigned BtbIdxW = $clog2(BtbSize);
    localparam int unsigned RasPtrW = $clog2(RasDepth);
    localparam logic [RasPtrW:0] RasFull = (RasPtrW + 1)'(RasDepth);

    // Architectural state
    logic [1:0]         r_bht     [BhtSize];
    logic               r_btb_vld [BtbSize];
    logic [BtbTagW-1:0] r_btb_tag [BtbSize];
    logic [31:0]        r_btb_tgt [BtbSize];
    logic [GhrLen-1:0]  r_ghr;
    logic [31:0]        r_ras     [RasDepth];
    logic [RasPtrW-1:0] r_ras_ptr;
    logic [RasPtrW:0]   r_ras_cnt;

    // Per-slot lookup
    logic [31:0]        w_pc       [2];
    logic [GhrLen-1:0]  w_ghr      [2];
    logic [BhtIdxW-1:0] w_bht_idx  [2];
    logic [BtbIdxW-1:0] w_btb_idx  [2];
    logic [BtbTagW-1:0] w_tag      [2];
    logic               w_btb_hit  [2];
    logic               w_cnt_tk   [2];
    logic [31:0]        w_btb_tgt  [2];
    logic [31:0]        w_ret_addr [2];

    logic               w_unused;

    assign w_pc[0]  = fetch_pc0_i;
    assign w_pc[1]  = fetch_pc1_i;
    assign w_ghr[0] = r_ghr;
    // Slot 1 sees slot 0's branch as not taken; if it were taken, slot 1 is dropped anyway
    assign w_ghr[1] = (fetch_valid_i[0] && fetch_is_br_i[0]) ? (r_ghr << 1) : r_ghr;

    assign pdt_ghr0_o = w_ghr[0];
    assign pdt_ghr1_o = w_ghr[1];

    assign w_unused = ^{fetch_pc0_i, fetch_pc1_i, ex_pc_i};

    // Table lookups for both fetch slots
    always_comb begin
        for (int unsigned k = 0; k < 2; k++) begin
            w_bht_idx[k]  = w_pc[k][BhtIdxW:1] ^ BhtIdxW'(w_ghr[k]);
            w_btb_idx[k]  = w_pc[k][BtbIdxW:1];
            w_tag[k]      = w_pc[k][BtbIdxW+BtbTagW:BtbIdxW+1];
            w_btb_hit[k]  = r_btb_vld[w_btb_idx[k]] && (r_btb_tag[w_btb_idx[k]] == w_tag[k]);
            w_cnt_tk[k]   = r_bht[w_bht_idx[k]][1];
            w_btb_tgt[k]  = r_btb_tgt[w_btb_idx[k]];
            w_ret_addr[k] = w_pc[k] + (fetch_is_comp_i[k] ? 32'd2 : 32'd4);
        end
    end

    // RAS view: slot 1 sees slot 0's push when slot 0 is an accepted call
    logic [RasPtrW-1:0] w_ras_top_idx;
    logic               w_ras_ne;
    logic [31:0]        w_ras_top;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_push0;
    logic [31:0]        w_ras_top1;
    logic               w_ras_ne1;

    assign w_ras_top_idx = r_ras_ptr - RasPtrW'(1);
    assign w_ras_ne      = (r_ras_cnt != '0);
    assign w_ras_top     = r_ras[w_ras_top_idx];
    assign w_acc0        = fetch_valid_i[0] & ds_rdy_i[0];
    assign w_push0       = w_acc0 & fetch_is_call_i[0];
    assign w_ras_top1    = w_push0 ? w_ret_addr[0] : w_ras_top;
    assign w_ras_ne1     = w_push0 | w_ras_ne;

    // Direction / target prediction and slot priority
    logic        w_pred0;
    logic        w_pred1;
    logic [31:0] w_tgt0;
    logic [31:0] w_tgt1;
    logic        w_tk0;
    logic        w_tk1;
    logic        w_vld1;

    assign w_pred0 = fetch_is_ret_i[0] ? w_ras_ne :
                     ((fetch_is_br_i[0] & w_cnt_tk[0] & w_btb_hit[0]) |
                      (fetch_is_jal_i[0] & w_btb_hit[0]));
    assign w_pred1 = fetch_is_ret_i[1] ? w_ras_ne1 :
                     ((fetch_is_br_i[1] & w_cnt_tk[1] & w_btb_hit[1]) |
                      (fetch_is_jal_i[1] & w_btb_hit[1]));
    assign w_tgt0  = fetch_is_ret_i[0] ? w_ras_top  : w_btb_tgt[0];
    assign w_tgt1  = fetch_is_ret_i[1] ? w_ras_top1 : w_btb_tgt[1];

    assign w_tk0  = fetch_valid_i[0] & w_pred0;
    assign w_vld1 = fetch_valid_i[1] & ~w_tk0;
    assign w_tk1  = w_vld1 & w_pred1;
    assign w_acc1 = w_vld1 & ds_rdy_i[1];

    assign pdt_valid_o         = {w_vld1, fetch_valid_i[0]};
    assign pdt_taken_o         = {w_tk1, w_tk0};
    assign predict_pc_set_o    = w_tk0 ? ds_rdy_i[0] : (w_tk1 & ds_rdy_i[1]);
    assign predict_pc_target_o = w_tk0 ? w_tgt0 : w_tgt1;

    // Next global history: fetch shifts in slot order, EX mispredict overrides
    logic [GhrLen-1:0] w_ghr_nxt;
    always_comb begin
        w_ghr_nxt = r_ghr;
        if (w_acc0 && fetch_is_br_i[0]) begin
            w_ghr_nxt = (w_ghr_nxt << 1) | GhrLen'(w_tk0);
        end
        if (w_acc1 && fetch_is_br_i[1]) begin
            w_ghr_nxt = (w_ghr_nxt << 1) | GhrLen'(w_tk1);
        end
        if (ex_valid_i && ex_mispredict_i) begin
            w_ghr_nxt = ex_is_br_i ? ((ex_ghr_i << 1) | GhrLen'(ex_taken_i)) : ex_ghr_i;
        end
    end

    // Next RAS pointer/count: slot 0 operation applied before slot 1
    logic [RasPtrW-1:0] w_ras_ptr_nxt;
    logic [RasPtrW:0]   w_ras_cnt_nxt;
    logic [1:0]         w_ras_we;
    logic [RasPtrW-1:0] w_ras_widx0;
    logic [RasPtrW-1:0] w_ras_widx1;
    always_comb begin
        w_ras_ptr_nxt = r_ras_ptr;
        w_ras_cnt_nxt = r_ras_cnt;
        w_ras_we      = '0;
        w_ras_widx0   = r_ras_ptr;
        w_ras_widx1   = r_ras_ptr;
        if (w_acc0 && fetch_is_call_i[0]) begin
            w_ras_we[0]   = 1'b1;
            w_ras_widx0   = w_ras_ptr_nxt;
            w_ras_ptr_nxt = w_ras_ptr_nxt + RasPtrW'(1);
            if (w_ras_cnt_nxt != RasFull) w_ras_cnt_nxt = w_ras_cnt_nxt + (RasPtrW + 1)'(1);
        end else if (w_acc0 && fetch_is_ret_i[0] && (w_ras_cnt_nxt != '0)) begin
            w_ras_ptr_nxt = w_ras_ptr_nxt - RasPtrW'(1);
            w_ras_cnt_nxt = w_ras_cnt_nxt - (RasPtrW + 1)'(1);
        end
        if (w_acc1 && fetch_is_call_i[1]) begin
            w_ras_we[1]   = 1'b1;
            w_ras_widx1   = w_ras_ptr_nxt;
            w_ras_ptr_nxt = w_ras_ptr_nxt + RasPtrW'(1);
            if (w_ras_cnt_nxt != RasFull) w_ras_cnt_nxt = w_ras_cnt_nxt + (RasPtrW + 1)'(1);
        end else if (w_acc1 && fetch_is_ret_i[1] && (w_ras_cnt_nxt != '0)) begin
            w_ras_ptr_nxt = w_ras_ptr_nxt - RasPtrW'(1);
            w_ras_cnt_nxt = w_ras_cnt_nxt - (RasPtrW + 1)'(1);
        end
    end

    // EX-side table update addresses and saturating counter
    logic [BhtIdxW-1:0] w_ex_bht_idx;
    logic [1:0]         w_ex_cnt;
    logic [1:0]         w_ex_cnt_nxt;
    logic [BtbIdxW-1:0] w_ex_btb_idx;
    logic [BtbTagW-1:0] w_ex_tag;

    assign w_ex_bht_idx = ex_pc_i[BhtIdxW:1] ^ BhtIdxW'(ex_ghr_i);
    assign w_ex_cnt     = r_bht[w_ex_bht_idx];
    assign w_ex_cnt_nxt = ex_taken_i ? ((w_ex_cnt == 2'd3) ? 2'd3 : w_ex_cnt + 2'd1)
                                     : ((w_ex_cnt == 2'd0) ? 2'd0 : w_ex_cnt - 2'd1);
    assign w_ex_btb_idx = ex_pc_i[BtbIdxW:1];
    assign w_ex_tag     = ex_pc_i[BtbIdxW+BtbTagW:BtbIdxW+1];

    // History and RAS pointer registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ghr     <= '0;
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else begin
            r_ghr     <= w_ghr_nxt;
            r_ras_ptr <= w_ras_ptr_nxt;
            r_ras_cnt <= w_ras_cnt_nxt;
        end
    end

    // Pattern history counters, reset to weakly taken
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BhtSize; i++) r_bht[i] <= 2'd2;
        end else if (ex_valid_i && ex_is_br_i) begin
            r_bht[w_ex_bht_idx] <= w_ex_cnt_nxt;
        end
    end

    // Branch target buffer, written for resolved taken branches and jumps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BtbSize; i++) begin
                r_btb_vld[i] <= 1'b0;
                r_btb_tag[i] <= '0;
                r_btb_tgt[i] <= '0;
            end
        end else if (ex_valid_i && ex_taken_i && (ex_is_br_i || ex_is_jal_i)) begin
            r_btb_vld[w_ex_btb_idx] <= 1'b1;
            r_btb_tag[w_ex_btb_idx] <= w_ex_tag;
            r_btb_tgt[w_ex_btb_idx] <= ex_target_i;
        end
    end

    // Return-address stack storage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RasDepth; i++) r_ras[i] <= '0;
        end else begin
            if (w_ras_we[0]) r_ras[w_ras_widx0] <= w_ret_addr[0];
            if (w_ras_we[1]) r_ras[w_ras_widx1] <= w_ret_addr[1];
        end
    end

endmodule
